grid_frame_sampler: RTL and testbench
=====================================

# grid_frame_sampler

Synthesizable frame-grid capture block for the snake display path. It sits beside the VGA timing and pixel-colour logic and snoops the `rgb`, `h_counter` and `v_counter` signals. At a fixed offset inside each cell of a configurable grid, it samples the pixel colour and classifies it into a cell code. The codes are buffered in a FIFO and emitted as a ready/valid stream with row and frame markers. It replaces the fixed 30×30, print-only frame dump with a parametrised, back-pressurable, armable capture usable on hardware and in benches.

## Interface
Parameters:
- `COLS`, 30, grid columns (1–64)
- `ROWS`, 30, grid rows (1–64)
- `CELL_PX`, 16, cell size in pixels, power of two (4–64)
- `H_ORIGIN`, 224, `h_counter` value of the first grid pixel column
- `V_ORIGIN`, 35, `v_counter` value of the first grid pixel line
- `SAMPLE_OFS`, 1, in-cell sample offset in both axes (< `CELL_PX`)
- `DEPTH`, 16, FIFO entries, power of two (≥ 2)
- `CONTINUOUS`, 0, 1 = re-arm automatically after each frame
- `C_BLACK`, `C_BLUE`, `C_RED`, `C_GREEN`: 8'h00, 8'h03, 8'hE0, 8'h1C; colours mapped to codes 0, 1, 2, 3

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous and active-high
- `pix_en` in 1: pixel-clock enable strobe; all snoop inputs are valid when high
- `h_counter`, `v_counter` in 10: current pixel position
- `rgb` in 8: current pixel colour
- `arm` in 1: request capture of the next frame
- `busy` out 1: armed or capturing
- `out_valid` out 1, `out_ready` in 1: stream handshake
- `out_code` out 3: bit 2 = unknown colour; bits 1:0 = code (0 when unknown)
- `out_sof` out 1: first cell of frame
- `out_eol` out 1: last cell of a row
- `out_eof` out 1: last cell of frame
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full
- `frame_done` out 1: one-cycle pulse when the last cell is written into the FIFO

## Operation
- FSM states: IDLE, WAIT_SOF, CAPTURE.
- IDLE → WAIT_SOF when `arm` = 1.
- WAIT_SOF → CAPTURE on the `pix_en` cycle where `h_counter` = `H_ORIGIN`+`SAMPLE_OFS` and `v_counter` = `V_ORIGIN`+`SAMPLE_OFS`. That sample is taken and marked `sof`.
- CAPTURE samples whenever `pix_en` = 1 and both conditions hold:
  - `h_counter` − `H_ORIGIN` ∈ [0, `COLS`·`CELL_PX`) and ≡ `SAMPLE_OFS` mod `CELL_PX`
  - `v_counter` − `V_ORIGIN` ∈ [0, `ROWS`·`CELL_PX`) and ≡ `SAMPLE_OFS` mod `CELL_PX`
- Column and row indices are counted internally: 6-bit col and 6-bit row. `eol` is set when col = `COLS`−1; `eof` when additionally row = `ROWS`−1.
- After the `eof` sample, CAPTURE → WAIT_SOF if `CONTINUOUS` = 1, else IDLE. `arm` is ignored outside IDLE.
- Classification: exact 8-bit match against `C_*`. No match gives code 3'b100.
- FIFO entries are {`sof`, `eol`, `eof`, code}, 6 bits.
- A sample that arrives while the FIFO is full is dropped and sets `overflow`. Indices still advance, so the frame stays geometrically aligned. `overflow` clears only on `rst`.
- Simultaneous push and pop while full: the pop frees the slot and the push is accepted.
- `busy` = state ≠ IDLE, or FIFO not empty.
- Reset mid-frame: all state is discarded, and the next capture starts only at a new frame origin.
- Reset values: `busy` 0, `out_valid` 0, `out_code` 0, `out_sof`/`out_eol`/`out_eof` 0, `overflow` 0, `frame_done` 0. FSM = IDLE, FIFO empty.

## Timing
- Sample to `out_valid`: 2 `clk` cycles. The sample is registered on the `pix_en` edge and written to the FIFO on the next cycle; `out_valid` is a registered FIFO-not-empty.
- Stream rules:
  - `out_*` are held stable while `out_valid` = 1 and `out_ready` = 0.
  - A transfer occurs when both are high.
  - Back-to-back transfers run at one per cycle.
- `frame_done` is asserted in the same cycle the `eof` entry is written.
- `arm` is level-sampled each cycle; a one-cycle pulse suffices.

## Configuration
- `GRID_SAMPLER_CHECKSUM_EN` defined: adds outputs `frame_sum` [15:0] and `frame_sum_valid`.
  - Per accepted sample: `sum` ← {`sum`[14:0], `sum`[15]} ^ {13'b0, code}.
  - `sum` is cleared at each `sof` sample.
  - `frame_sum` is latched and `frame_sum_valid` pulses together with `frame_done`.
  - Dropped samples are still summed.
  - Reset value of both outputs is 0.
- Undefined: no checksum logic and no such ports.

## Test plan
- Defaults, all-black frame, `arm` pulse, `out_ready` = 1 → exactly 900 beats of code 0, 30 `eol`, one `sof`/`eof`; `frame_done` once; `busy` falls after the last beat.
- Cell (col 2, row 0) painted `C_RED`, others `C_BLUE` → beat 2 code 2, all others code 1.
- `rgb` = 8'hFF at cell (0,0) → first beat `out_code` = 3'b100 with `sof` = 1.
- `out_ready` = 0 for a whole frame, `DEPTH` = 16 → 16 beats retained, `overflow` = 1. On release, beats 0–15 emerge intact, then no further beats.
- `CONTINUOUS` = 1 across 3 frames → 3 `frame_done` pulses, 2700 beats. `rst` asserted mid-frame 2 → capture resumes only at the frame 3 origin.
- With `GRID_SAMPLER_CHECKSUM_EN`, all-blue 30×30 frame → `frame_sum` equals the bench-computed rotate-xor value, and it is identical on two consecutive frames.

Source files
------------

// File: rtl/grid_frame_sampler.sv
// grid_frame_sampler: samples one pixel per grid cell, classifies it and streams {sof,eol,eof,code}.
// Latency: sample on pix_en edge -> out_valid two clk later; backpressure: FIFO absorbs, full drops set sticky overflow.
// Optional checksum outputs (frame_sum, frame_sum_valid) when GRID_SAMPLER_CHECKSUM_EN is defined.

module sampler_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          push, pop;

    assign pop_vld = (cnt != '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign pop     = pop_vld && pop_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push    = push_vld && (!full || pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module grid_frame_sampler #(
    parameter int         COLS       = 30,
    parameter int         ROWS       = 30,
    parameter int         CELL_PX    = 16,
    parameter int         H_ORIGIN   = 224,
    parameter int         V_ORIGIN   = 35,
    parameter int         SAMPLE_OFS = 1,
    parameter int         DEPTH      = 16,
    parameter int         CONTINUOUS = 0,
    parameter logic [7:0] C_BLACK    = 8'h00,
    parameter logic [7:0] C_BLUE     = 8'h03,
    parameter logic [7:0] C_RED      = 8'hE0,
    parameter logic [7:0] C_GREEN    = 8'h1C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    input  logic [7:0]  rgb,
    input  logic        arm,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_code,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic        overflow,
    output logic        frame_done
`ifdef GRID_SAMPLER_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum,
    output logic        frame_sum_valid
`endif
);
    localparam int         LG     = $clog2(CELL_PX);
    localparam logic [12:0] H_SPAN = 13'(COLS * CELL_PX);
    localparam logic [12:0] V_SPAN = 13'(ROWS * CELL_PX);
    localparam logic [9:0]  H_SOF  = 10'(H_ORIGIN + SAMPLE_OFS);
    localparam logic [9:0]  V_SOF  = 10'(V_ORIGIN + SAMPLE_OFS);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

    state_t      state, state_nxt;
    logic [12:0] dh, dv;
    logic        h_hit, v_hit, origin_hit;
    logic        take, cur_sof, cur_eol, cur_eof;
    logic [5:0]  col, row, cur_col, cur_row;
    logic [2:0]  code;
    logic        s_vld;
    logic [5:0]  s_dat;
    logic        f_vld, f_full, drop;
    logic [5:0]  f_dat;

    // Positions left of / above the origin wrap to huge values and fail the span test.
    assign dh         = {3'b000, h_counter} - 13'(H_ORIGIN);
    assign dv         = {3'b000, v_counter} - 13'(V_ORIGIN);
    assign h_hit      = (dh < H_SPAN) && (dh[LG-1:0] == LG'(SAMPLE_OFS));
    assign v_hit      = (dv < V_SPAN) && (dv[LG-1:0] == LG'(SAMPLE_OFS));
    assign origin_hit = (h_counter == H_SOF) && (v_counter == V_SOF);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (arm) state_nxt = WAIT_SOF;
            WAIT_SOF,
            CAPTURE:  if (take) state_nxt = cur_eof ? ((CONTINUOUS != 0) ? WAIT_SOF : IDLE) : CAPTURE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        take    = 1'b0;
        cur_sof = 1'b0;
        cur_col = col;
        cur_row = row;
        case (state)
            WAIT_SOF: begin
                take    = pix_en && origin_hit;
                cur_sof = 1'b1;
                cur_col = '0;
                cur_row = '0;
            end
            CAPTURE:  take = pix_en && h_hit && v_hit;
            default:  ;
        endcase
        cur_eol = (cur_col == 6'(COLS - 1));
        cur_eof = cur_eol && (cur_row == 6'(ROWS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (take) begin
            if (cur_eol) begin
                col <= '0;
                row <= cur_row + 6'd1;
            end else begin
                col <= cur_col + 6'd1;
                row <= cur_row;
            end
        end
    end

    always_comb begin
        if      (rgb == C_BLACK) code = 3'b000;
        else if (rgb == C_BLUE)  code = 3'b001;
        else if (rgb == C_RED)   code = 3'b010;
        else if (rgb == C_GREEN) code = 3'b011;
        else                     code = 3'b100;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_vld <= 1'b0;
            s_dat <= '0;
        end else begin
            s_vld <= take;
            if (take) s_dat <= {cur_sof, cur_eol, cur_eof, code};
        end
    end

    sampler_fifo #(.W(6), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (s_vld),
        .push_dat (s_dat),
        .pop_rdy  (out_ready),
        .pop_vld  (f_vld),
        .pop_dat  (f_dat),
        .full     (f_full)
    );

    assign drop = s_vld && f_full && !(f_vld && out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            overflow   <= overflow | drop;
            frame_done <= s_vld && s_dat[3];
        end
    end

    assign out_valid = f_vld;
    assign {out_sof, out_eol, out_eof, out_code} = f_vld ? f_dat : 6'd0;
    assign busy = (state != IDLE) || s_vld || f_vld;

`ifdef GRID_SAMPLER_CHECKSUM_EN
    logic [15:0] sum, sum_nxt;

    // Dropped samples are summed too, so the checksum reflects the frame, not the FIFO.
    assign sum_nxt = (s_dat[5] ? 16'h0000 : {sum[14:0], sum[15]}) ^ {13'b0, s_dat[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum             <= '0;
            frame_sum       <= '0;
            frame_sum_valid <= 1'b0;
        end else begin
            frame_sum_valid <= s_vld && s_dat[3];
            if (s_vld) begin
                sum <= sum_nxt;
                if (s_dat[3]) frame_sum <= sum_nxt;
            end
        end
    end
`endif
endmodule

// File: tb/tb_grid_frame_sampler.sv
// Bench for grid_frame_sampler: random scan timing, noise pixels and stalls checked against a per-frame cell model.
module tb_grid_frame_sampler;
    localparam int COLS  = 5;
    localparam int ROWS  = 4;
    localparam int CELL  = 4;
    localparam int HO    = 3;
    localparam int VO    = 2;
    localparam int OFS   = 1;
    localparam int DEPTH = 8;
    localparam int HT    = 28;
    localparam int VT    = 20;
    localparam int NCELL = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       arm_a = 1'b0, arm_c = 1'b0;
    logic       ready_a = 1'b1, ready_c = 1'b1;
    logic [9:0] h_counter = '0, v_counter = '0;
    logic [7:0] rgb = '0;

    logic       a_busy, a_valid, a_sof, a_eol, a_eof, a_ovf, a_fd;
    logic       c_busy, c_valid, c_sof, c_eol, c_eof, c_ovf, c_fd;
    logic [2:0] a_code, c_code;
`ifdef GRID_SAMPLER_CHECKSUM_EN
    logic [15:0] a_sum, c_sum;
    logic        a_sumv, c_sumv;
`endif

    int          checks = 0, errors = 0;
    int          ready_mode = 0;
    logic [7:0]  img [ROWS][COLS];
    logic [5:0]  qa[$], qc[$];
    logic [15:0] exp_sum = '0;
    int          a_beats = 0, c_beats = 0, a_done = 0, c_done = 0;

    always #5 clk = ~clk;

    grid_frame_sampler #(.COLS(COLS), .ROWS(ROWS), .CELL_PX(CELL), .H_ORIGIN(HO), .V_ORIGIN(VO),
                         .SAMPLE_OFS(OFS), .DEPTH(DEPTH), .CONTINUOUS(0)) dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_counter(h_counter), .v_counter(v_counter),
        .rgb(rgb), .arm(arm_a), .busy(a_busy), .out_valid(a_valid), .out_ready(ready_a),
        .out_code(a_code), .out_sof(a_sof), .out_eol(a_eol), .out_eof(a_eof),
        .overflow(a_ovf), .frame_done(a_fd)
`ifdef GRID_SAMPLER_CHECKSUM_EN
        , .frame_sum(a_sum), .frame_sum_valid(a_sumv)
`endif
    );

    grid_frame_sampler #(.COLS(COLS), .ROWS(ROWS), .CELL_PX(CELL), .H_ORIGIN(HO), .V_ORIGIN(VO),
                         .SAMPLE_OFS(OFS), .DEPTH(DEPTH), .CONTINUOUS(1)) dut_c (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_counter(h_counter), .v_counter(v_counter),
        .rgb(rgb), .arm(arm_c), .busy(c_busy), .out_valid(c_valid), .out_ready(ready_c),
        .out_code(c_code), .out_sof(c_sof), .out_eol(c_eol), .out_eof(c_eof),
        .overflow(c_ovf), .frame_done(c_fd)
`ifdef GRID_SAMPLER_CHECKSUM_EN
        , .frame_sum(c_sum), .frame_sum_valid(c_sumv)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] cls(input logic [7:0] c);
        case (c)
            8'h00:   return 3'd0;
            8'h03:   return 3'd1;
            8'hE0:   return 3'd2;
            8'h1C:   return 3'd3;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'h03;
            2:       return 8'hE0;
            3:       return 8'h1C;
            default: return 8'($urandom);
        endcase
    endfunction

    // Only the sample pixel of each cell carries the cell colour; everything else is noise.
    function automatic logic [7:0] colour(input int h, input int v);
        int dh = h - HO;
        int dv = v - VO;
        if (dh >= 0 && dv >= 0 && dh < COLS * CELL && dv < ROWS * CELL &&
            dh % CELL == OFS && dv % CELL == OFS)
            return img[dv / CELL][dh / CELL];
        return 8'($urandom);
    endfunction

    task automatic set_image(input int mode);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                case (mode)
                    0:       img[r][c] = 8'h00;
                    1:       img[r][c] = (r == 0 && c == 2) ? 8'hE0 : 8'h03;
                    4:       img[r][c] = 8'h03;
                    default: img[r][c] = pick();
                endcase
        if (mode == 3) img[0][0] = 8'hFF;
    endtask

    task automatic expect_frame(input bit to_a, input bit to_c, input int keep_a);
        logic [15:0] s = '0;
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                logic [2:0] k = cls(img[r][c]);
                logic first = (r == 0 && c == 0);
                logic last_c = (c == COLS - 1);
                logic [5:0] beat = {first, last_c, last_c && (r == ROWS - 1), k};
                s = first ? 16'(k) : ({s[14:0], s[15]} ^ 16'(k));
                if (to_a && n < keep_a) qa.push_back(beat);
                if (to_c) qc.push_back(beat);
                n++;
            end
        exp_sum = s;
    endtask

    task automatic pixel(input int h, input int v);
        h_counter = 10'(h);
        v_counter = 10'(v);
        rgb       = colour(h, v);
        pix_en    = 1'b0;
        while ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
    endtask

    task automatic scan_lines(input int v0, input int v1);
        for (int v = v0; v < v1; v++)
            for (int h = 0; h < HT; h++)
                pixel(h, v);
    endtask

    task automatic pulse_arm(input logic a, input logic c);
        arm_a = a;
        arm_c = c;
        @(posedge clk); #1;
        arm_a = 1'b0;
        arm_c = 1'b0;
    endtask

    task automatic drain(input logic c_busy_exp);
        int n = 0;
        while ((qa.size() != 0 || qc.size() != 0 || a_busy || (!c_busy_exp && c_busy)) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_qa", qa.size(), 0);
        chk("drain_qc", qc.size(), 0);
        chk("busy_a_low", a_busy, 0);
        chk("busy_c", c_busy, c_busy_exp);
    endtask

    initial forever begin
        @(posedge clk); #1;
        ready_a = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 0);
    end

    logic [5:0] a_prev = '0, c_prev = '0;
    logic       a_stall = 1'b0, c_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) a_stall = 1'b0;
        else begin
            if (a_stall) begin
                chk("a_hold_valid", a_valid, 1);
                chk("a_hold_beat", {a_sof, a_eol, a_eof, a_code}, a_prev);
            end
            if (a_valid && ready_a) begin
                a_beats++;
                if (qa.size() == 0) chk("a_unexpected_beat", qa.size(), 1);
                else chk("a_beat", {a_sof, a_eol, a_eof, a_code}, qa.pop_front());
            end
            if (a_fd) begin
                a_done++;
`ifdef GRID_SAMPLER_CHECKSUM_EN
                chk("a_sum_valid", a_sumv, 1);
                chk("a_frame_sum", a_sum, exp_sum);
`endif
            end
            a_stall = a_valid && !ready_a;
            a_prev  = {a_sof, a_eol, a_eof, a_code};
        end
    end

    always @(negedge clk) begin
        if (rst) c_stall = 1'b0;
        else begin
            if (c_stall) chk("c_hold_valid", c_valid, 1);
            if (c_valid && ready_c) begin
                c_beats++;
                if (qc.size() == 0) chk("c_unexpected_beat", qc.size(), 1);
                else chk("c_beat", {c_sof, c_eol, c_eof, c_code}, qc.pop_front());
            end
            if (c_fd) begin
                c_done++;
`ifdef GRID_SAMPLER_CHECKSUM_EN
                chk("c_sum_valid", c_sumv, 1);
                chk("c_frame_sum", c_sum, exp_sum);
`endif
            end
            c_stall = c_valid && !ready_c;
            c_prev  = {c_sof, c_eol, c_eof, c_code};
        end
    end

    initial begin
        #2000000;
        chk("timeout", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, base_done;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_code", a_code, 0);
        chk("rst_markers", {a_sof, a_eol, a_eof}, 0);
        chk("rst_overflow", a_ovf, 0);
        chk("rst_frame_done", a_fd, 0);
        chk("rst_c_busy", c_busy, 0);
        chk("rst_c_valid", c_valid, 0);
`ifdef GRID_SAMPLER_CHECKSUM_EN
        chk("rst_sum", a_sum, 0);
        chk("rst_sum_valid", a_sumv, 0);
`endif
        rst = 1'b0;

        set_image(2);
        scan_lines(0, VT);
        drain(1'b0);
        chk("unarmed_no_beats", a_beats, 0);

        pulse_arm(1'b1, 1'b0);
        set_image(0);
        expect_frame(1'b1, 1'b0, NCELL);
        scan_lines(0, VT);
        drain(1'b0);
        chk("black_beats", a_beats, NCELL);
        chk("black_done", a_done, 1);

        ready_mode = 1;
        for (int i = 0; i < 5; i++) begin
            pulse_arm(1'b1, 1'b0);
            set_image(i == 0 ? 1 : (i == 1 ? 3 : 2));
            expect_frame(1'b1, 1'b0, NCELL);
            scan_lines(0, VT);
            drain(1'b0);
        end
        chk("stall_beats", a_beats, 6 * NCELL);
        chk("stall_done", a_done, 6);
        chk("no_overflow_yet", a_ovf, 0);

        base = a_beats;
        ready_mode = 2;
        pulse_arm(1'b1, 1'b0);
        set_image(2);
        expect_frame(1'b1, 1'b0, DEPTH);
        scan_lines(0, VT);
        chk("ovf_set", a_ovf, 1);
        chk("ovf_full_valid", a_valid, 1);
        ready_mode = 0;
        drain(1'b0);
        chk("ovf_beats", a_beats - base, DEPTH);
        set_image(2);
        scan_lines(0, VT);
        drain(1'b0);
        chk("ovf_sticky", a_ovf, 1);
        chk("ovf_no_more", a_beats - base, DEPTH);

        base_done = a_done;
        pulse_arm(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_image(i < 2 ? 4 : 2);
            expect_frame(1'b0, 1'b1, 0);
            scan_lines(0, VT);
            drain(1'b1);
        end
        chk("cont_done", c_done, 3);
        chk("cont_beats", c_beats, 3 * NCELL);
        chk("a_not_rearmed", a_done, base_done);

        set_image(2);
        expect_frame(1'b0, 1'b1, 0);
        scan_lines(0, VT / 2);
        rst = 1'b1;
        qc.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ovf_clear", a_ovf, 0);
        chk("rst_mid_c_busy", c_busy, 0);
        chk("rst_mid_c_valid", c_valid, 0);
        rst = 1'b0;
        base = c_beats;
        base_done = c_done;
        pulse_arm(1'b0, 1'b1);
        scan_lines(VT / 2, VT);
        chk("no_resume_midframe", c_beats - base, 0);
        set_image(2);
        expect_frame(1'b0, 1'b1, 0);
        scan_lines(0, VT);
        drain(1'b1);
        chk("resume_beats", c_beats - base, NCELL);
        chk("resume_done", c_done - base_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
